// File: rtl/screen_fetcher_if.sv
// Screen fetcher bus: raster position, video SRAM port and pixel output.
// master drives raster/SRAM data, slave is the fetcher itself.
interface screen_fetcher_if;
    logic        ck7;
    logic [8:0]  hc;
    logic [8:0]  vc;
    logic        blink;
    logic [7:0]  vd;
    logic        screen_fetch;
    logic [14:0] screen_addr;
    logic        pixel_valid;
    logic        ink;
    logic [7:0]  attr;

    modport master (
        output ck7, hc, vc, blink, vd,
        input  screen_fetch, screen_addr, pixel_valid, ink, attr
    );

    modport slave (
        input  ck7, hc, vc, blink, vd,
        output screen_fetch, screen_addr, pixel_valid, ink, attr
    );
endinterface

// File: rtl/screen_fetcher.sv
// Screen fetcher: reads bitmap/attribute bytes per character cell
// and serialises them into ink/paper pixels with 8-pixel latency.
module screen_fetcher #(
    parameter bit FLASH_EN = 1'b1
) (
    input  logic             clk28,
    input  logic             rst_n,
    screen_fetcher_if.slave  bus
);
    localparam logic [2:0] PH_BM   = 3'd2;
    localparam logic [2:0] PH_AT   = 3'd4;
    localparam logic [2:0] PH_LOAD = 3'd7;

    logic        w_area;
    logic [4:0]  w_col;
    logic [2:0]  w_phase;
    logic [14:0] w_bm_addr;
    logic [14:0] w_at_addr;

    logic [7:0]  r_bm_latch;
    logic [7:0]  r_at_latch;
    logic [7:0]  r_shift;
    logic [7:0]  r_attr;
    logic        r_flash;
    logic        r_pixel_valid;

    assign w_area  = (bus.hc < 9'd256) && (bus.vc < 9'd192);
    assign w_col   = bus.hc[7:3];
    assign w_phase = bus.hc[2:0];

    assign w_bm_addr = {2'b00, bus.vc[7:6], bus.vc[2:0],
                        bus.vc[5:3], w_col};
    assign w_at_addr = {2'b00, 3'b110, bus.vc[7:3], w_col};

    assign bus.screen_fetch = w_area &&
                              (w_phase == PH_BM || w_phase == PH_AT);
    assign bus.screen_addr  = (w_phase == PH_AT) ? w_at_addr
                                                 : w_bm_addr;

    assign bus.ink         = r_shift[7] ^ r_flash;
    assign bus.attr        = r_attr;
    assign bus.pixel_valid = r_pixel_valid;

    // Capture SRAM read data at the end of each fetch slot.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_bm_latch <= 8'h00;
            r_at_latch <= 8'h00;
        end else if (bus.ck7 && w_area) begin
            if (w_phase == PH_BM)
                r_bm_latch <= bus.vd;
            if (w_phase == PH_AT)
                r_at_latch <= bus.vd;
        end
    end

    // Load the cell at phase 7, otherwise shift one pixel out.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= 8'h00;
            r_attr        <= 8'h00;
            r_flash       <= 1'b0;
            r_pixel_valid <= 1'b0;
        end else if (bus.ck7) begin
            if (w_phase == PH_LOAD) begin
                if (w_area) begin
                    r_shift       <= r_bm_latch;
                    r_attr        <= r_at_latch;
                    r_flash       <= r_at_latch[7] & bus.blink
                                     & FLASH_EN;
                    r_pixel_valid <= 1'b1;
                end else begin
                    r_shift       <= 8'h00;
                    r_attr        <= 8'h00;
                    r_flash       <= 1'b0;
                    r_pixel_valid <= 1'b0;
                end
            end else begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_screen_fetcher.sv
// Bench for screen_fetcher: raster-position model of pixel output,
// checked every cycle on two instances (flash on / flash off).
module tb_screen_fetcher;
    logic       clk28;
    logic       rst_n;
    logic       ck7;
    logic [8:0] hc;
    logic [8:0] vc;
    logic       blink;
    logic       vd_ovr_en;
    logic [7:0] vd_ovr;

    logic [7:0] vram [32768];

    int  n_chk;
    int  n_fail;
    bit  chk_en;
    bit  stall;
    int  m_hc;
    int  m_vc;

    int       fcount [448];
    int       faddr  [448];
    logic     ink1_log [448];
    logic     ink2_log [448];
    logic     pv_log   [448];
    logic [7:0] at_log [448];

    typedef struct packed {
        logic       v;
        logic       i;
        logic [7:0] a;
    } exp_t;

    screen_fetcher_if b1 ();
    screen_fetcher_if b2 ();

    assign b1.ck7   = ck7;
    assign b1.hc    = hc;
    assign b1.vc    = vc;
    assign b1.blink = blink;
    assign b1.vd    = vd_ovr_en ? vd_ovr : vram[b1.screen_addr];
    assign b2.ck7   = ck7;
    assign b2.hc    = hc;
    assign b2.vc    = vc;
    assign b2.blink = blink;
    assign b2.vd    = vd_ovr_en ? vd_ovr : vram[b2.screen_addr];

    screen_fetcher #(.FLASH_EN(1'b1)) dut1 (
        .clk28 (clk28),
        .rst_n (rst_n),
        .bus   (b1)
    );

    screen_fetcher #(.FLASH_EN(1'b0)) dut2 (
        .clk28 (clk28),
        .rst_n (rst_n),
        .bus   (b2)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (vc=%0d hc=%0d)",
                     nm, act, exp, vc, hc);
        end
    endtask

    function automatic int bm_addr(int v, int c);
        return ((v / 64) % 4) * 2048 + (v % 8) * 256
             + ((v / 8) % 8) * 32 + c;
    endfunction

    function automatic int at_addr(int v, int c);
        return 6144 + (v / 8) * 32 + c;
    endfunction

    // Pixel at column h of line v comes from cell (h-8)/8, bit (h-8)%8.
    function automatic exp_t model(int h, int v, bit fe);
        exp_t e;
        logic [7:0] bm;
        logic [7:0] at;
        int c;
        int b;
        e = '0;
        if (v < 192 && h >= 8 && h <= 263) begin
            c   = (h - 8) / 8;
            b   = (h - 8) % 8;
            bm  = vram[bm_addr(v, c)];
            at  = vram[at_addr(v, c)];
            e.v = 1'b1;
            e.a = at;
            e.i = bm[7 - b] ^ (fe & at[7] & blink);
        end
        return e;
    endfunction

    // Per-cycle comparison of both instances against the model.
    initial begin
        exp_t e1;
        exp_t e2;
        int   h;
        int   v;
        bit   f;
        int   a;
        forever begin
            @(negedge clk28);
            #2;
            if (chk_en && rst_n) begin
                e1 = model(m_hc, m_vc, 1'b1);
                e2 = model(m_hc, m_vc, 1'b0);
                chk("pv1",   16'(b1.pixel_valid), 16'(e1.v));
                chk("ink1",  16'(b1.ink),         16'(e1.i));
                chk("attr1", 16'(b1.attr),        16'(e1.a));
                chk("pv2",   16'(b2.pixel_valid), 16'(e2.v));
                chk("ink2",  16'(b2.ink),         16'(e2.i));
                chk("attr2", 16'(b2.attr),        16'(e2.a));
                if (!stall) begin
                    h = int'(hc);
                    v = int'(vc);
                    f = (h < 256) && (v < 192)
                        && (h % 8 == 2 || h % 8 == 4);
                    chk("fetch1", 16'(b1.screen_fetch), 16'(f));
                    chk("fetch2", 16'(b2.screen_fetch), 16'(f));
                    if (f) begin
                        a = (h % 8 == 4) ? at_addr(v, h / 8)
                                         : bm_addr(v, h / 8);
                        chk("addr1", 16'(b1.screen_addr), 16'(a));
                        chk("addr2", 16'(b2.screen_addr), 16'(a));
                    end
                end
            end
        end
    end

    // One pixel: hc held 4 clk28, ck7 high in the last of them.
    task automatic pixel(input int h, input int v, input bit do_rst);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk28);
            if (k == 0) begin
                hc    = 9'(h);
                vc    = 9'(v);
                m_hc  = h;
                m_vc  = v;
                stall = 1'b0;
            end
            ck7 = (k == 3);
            #2;
            if (k == 0) begin
                ink1_log[h] = b1.ink;
                ink2_log[h] = b2.ink;
                pv_log[h]   = b1.pixel_valid;
                at_log[h]   = b1.attr;
            end
            if (b1.screen_fetch) begin
                fcount[h]++;
                faddr[h] = int'(b1.screen_addr);
            end
            if (do_rst && k == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ink1",  16'(b1.ink),         16'h0);
                chk("rst_pv1",   16'(b1.pixel_valid), 16'h0);
                chk("rst_attr1", 16'(b1.attr),        16'h0);
                chk("rst_ink2",  16'(b2.ink),         16'h0);
            end
            if (do_rst && k == 1)
                rst_n = 1'b1;
        end
    endtask

    // Hold ck7 low for 100 clk28 while scrambling hc/vc/vd.
    task automatic stall_ck7(input int h);
        m_hc  = h + 1;
        stall = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk28);
            ck7       = 1'b0;
            hc        = 9'($urandom_range(0, 447));
            vc        = 9'($urandom_range(0, 319));
            vd_ovr    = 8'($urandom);
            vd_ovr_en = 1'b1;
        end
        vd_ovr_en = 1'b0;
    endtask

    task automatic run_line(input int v, input bit bl, input int h_end);
        blink = bl;
        for (int i = 0; i < 448; i++) begin
            fcount[i] = 0;
            faddr[i]  = -1;
        end
        for (int h = 0; h <= h_end; h++) begin
            chk_en = !(v == 3 && h >= 100 && h <= 111);
            pixel(h, v, v == 3 && h == 100);
            if (v == 2 && h == 50)
                stall_ck7(h);
        end
        chk_en = 1'b1;
    endtask

    initial begin
        int s;
        n_chk     = 0;
        n_fail    = 0;
        chk_en    = 1'b0;
        stall     = 1'b0;
        rst_n     = 1'b0;
        ck7       = 1'b0;
        hc        = 9'd0;
        vc        = 9'd0;
        blink     = 1'b0;
        vd_ovr    = 8'h00;
        vd_ovr_en = 1'b0;
        m_hc      = 0;
        m_vc      = 0;
        for (int i = 0; i < 32768; i++)
            vram[i] = 8'((i * 37 + 11) ^ (i >> 7));
        vram[15'h0000] = 8'hA5;
        vram[15'h1800] = 8'h47;
        vram[15'h0101] = 8'hF0;
        vram[15'h1801] = 8'hC7;
        vram[15'h180C] = 8'h38;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk28);
            ck7 = (i % 4 == 3);
        end
        #2;
        chk("reset_ink",  16'(b1.ink),         16'h0);
        chk("reset_pv",   16'(b1.pixel_valid), 16'h0);
        chk("reset_attr", 16'(b1.attr),        16'h0);
        @(negedge clk28);
        ck7    = 1'b0;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_line(0, 1'b0, 447);
        chk("l0_bm_cycles", 16'(fcount[2]), 16'd4);
        chk("l0_bm_addr",   16'(faddr[2]),  16'h0000);
        chk("l0_at_cycles", 16'(fcount[4]), 16'd4);
        chk("l0_at_addr",   16'(faddr[4]),  16'h1800);
        s = fcount[0] + fcount[1] + fcount[3]
          + fcount[5] + fcount[6] + fcount[7];
        chk("l0_idle_fetch", 16'(s), 16'd0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'hA5;
            chk("l0_ink", 16'(ink1_log[8 + i]), 16'(pat[7 - i]));
        end
        chk("l0_attr",   16'(at_log[8]),   16'h47);
        chk("l0_pv",     16'(pv_log[8]),   16'h1);
        chk("l0_pv263",  16'(pv_log[263]), 16'h1);
        chk("l0_pv264",  16'(pv_log[264]), 16'h0);
        chk("l0_pv7",    16'(pv_log[7]),   16'h0);

        run_line(1, 1'b1, 447);
        for (int i = 0; i < 8; i++) begin
            chk("l1_ink_flash",   16'(ink1_log[16 + i]),
                16'(i >= 4));
            chk("l1_ink_noflash", 16'(ink2_log[16 + i]),
                16'(i < 4));
        end
        chk("l1_attr", 16'(at_log[16]), 16'hC7);

        run_line(2, 1'b1, 447);

        run_line(3, 1'b0, 447);
        for (int i = 104; i < 112; i++) begin
            chk("rst_line_pv",  16'(pv_log[i]),   16'h1);
            chk("rst_line_ink", 16'(ink1_log[i]), 16'h0);
            chk("rst_line_at",  16'(at_log[i]),   16'h38);
        end

        run_line(191, 1'b1, 447);
        chk("l191_bm_addr", 16'(faddr[250]),  16'h17FF);
        chk("l191_at_addr", 16'(faddr[252]),  16'h1AFF);
        chk("l191_fetch256", 16'(fcount[256]), 16'd0);

        run_line(192, 1'b0, 447);
        s = 0;
        for (int i = 0; i < 448; i++)
            s += fcount[i] + int'(pv_log[i]);
        chk("l192_quiet", 16'(s), 16'd0);

        run_line(319, 1'b0, 447);
        run_line(0, 1'b0, 20);
        chk("wrap_ink", 16'(ink1_log[8]), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/screen_fetcher.md
SCREEN_FETCHER -- requirements
Module: screen_fetcher

Interface
REQ-001 SHALL have parameter: FLASH_EN, 1, when 1 attribute bit 7 XORs ink with blink; when 0 bit 7 is ignored for ink.
REQ-002 SHALL have port: clk28  in  1  system clock, 28 MHz.
REQ-003 SHALL have port: rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: ck7  in  1  pixel strobe, one clk28 cycle high in every 4; all state advances only when ck7=1.
REQ-005 SHALL have port: hc  in  9  pixel column 0..447, registered upstream, advances on ck7 edges.
REQ-006 SHALL have port: vc  in  9  line 0..319, registered upstream.
REQ-007 SHALL have port: blink  in  1  flash phase.
REQ-008 SHALL have port: vd  in  8  video SRAM read data.
REQ-009 SHALL have port: screen_fetch  out  1  video SRAM read request to memory controller.
REQ-010 SHALL have port: screen_addr  out  15  byte address within the 16K screen page.
REQ-011 SHALL have port: pixel_valid  out  1  ink/attr describe a paper-area pixel.
REQ-012 SHALL have port: ink  out  1  current pixel is ink (1) or paper (0).
REQ-013 SHALL have port: attr  out  8  attribute byte of the current character cell.

Function
REQ-014 SHALL define fetch_area = (hc < 256) && (vc < 192); char column col = hc[7:3], phase = hc[2:0].
REQ-015 SHALL drive screen_fetch = fetch_area && (phase==2 || phase==4), combinational from hc/vc, i.e. exactly 4 clk28 cycles per read, 2 reads per char column.
REQ-016 SHALL drive screen_addr at phase 2 (bitmap) = {2'b00, vc[7:6], vc[2:0], vc[5:3], col}.
REQ-017 SHALL drive screen_addr at phase 4 (attribute) = {2'b00, 3'b110, vc[7:3], col}; outside those phases screen_addr SHALL hold the bitmap address.
REQ-018 SHALL capture vd into bitmap_latch on the clk28 edge where ck7=1, fetch_area=1, phase==2; into attr_latch where phase==4.
REQ-019 SHALL on the edge where ck7=1 and phase==7: if fetch_area, load shift<=bitmap_latch, attr<=attr_latch, flash<=attr_latch[7]&blink&FLASH_EN, pixel_valid<=1; else shift<=0, attr<=0, flash<=0, pixel_valid<=0.
REQ-020 SHALL on every other ck7 edge shift left by one, inserting 0; attr, flash, pixel_valid hold.
REQ-021 SHALL drive ink = shift[7] ^ flash.
REQ-022 SHALL thus give pixel latency of exactly 8 pixels: column c displays during hc 8c+8..8c+15; paper spans hc 8..263.
REQ-023 SHALL change no register when ck7=0, regardless of hc/vc/vd activity.
REQ-024 SHALL hold latches unchanged outside fetch_area; stale latches are never loaded because REQ-019 gates on fetch_area.
REQ-025 SHALL treat hc wrap 447->0 and vc wrap 319->0 with no special state; next line's column 0 fetch begins at hc 0.

Reset
REQ-026 SHALL, while rst_n=0, force bitmap_latch, attr_latch, shift, attr, flash, pixel_valid to 0 (ink=0); screen_fetch/screen_addr remain combinational from hc/vc.
REQ-027 SHALL after rst_n deasserts mid-line resume at the next phase-7 edge; the first load of a line after mid-line reset may present zero latches if their fetch phase was missed.

Verification
REQ-028 SHALL check: vc=0, hc sweeps 0..7 -> screen_fetch high 4 clk28 at phase 2 addr 0x0000, 4 clk28 at phase 4 addr 0x1800.
REQ-029 SHALL check: vc=191, hc=248..255 -> bitmap addr 0x17FF, attr addr 0x1AFF; hc=256 -> screen_fetch=0.
REQ-030 SHALL check: vd=0xA5 at bitmap, 0x47 at attr, blink=0 -> hc 8..15 ink=1,0,1,0,0,1,0,1, attr=0x47, pixel_valid=1.
REQ-031 SHALL check: attr 0xC7, blink=1, bitmap 0xF0 -> ink=0,0,0,0,1,1,1,1; FLASH_EN=0 -> ink=1,1,1,1,0,0,0,0.
REQ-032 SHALL check: hc passes 263 -> pixel_valid drops at the phase-7 edge of hc=263; vc=192 entire line -> screen_fetch never asserts, pixel_valid=0.
REQ-033 SHALL check: rst_n pulsed low at hc=100 -> outputs 0 immediately; ck7 held 0 for 100 clk28 -> no register changes.
